// File: rtl/dma_desc_queue.sv
// rtl/dma_desc_queue.sv - DMA descriptor/response queue with run/flush control

module dma_queue_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
endmodule

module dma_desc_queue #(
    parameter int DESC_DEPTH  = 8,
    parameter int RESP_DEPTH  = 8,
    parameter int DESC_DATA_W = 64
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          aenable,
    input  logic                          i_flush,
    input  logic                          i_host_desc_wr,
    input  logic [7:0]                    i_host_desc_id,
    input  logic [1:0]                    i_host_desc_ch,
    input  logic [DESC_DATA_W-1:0]        i_host_desc_data,
    output logic                          o_host_desc_wready,
    output logic                          o_desc_rready,
    output logic [1:0]                    o_desc_ch_sel,
    output logic [7:0]                    o_desc_id,
    output logic [DESC_DATA_W-1:0]        o_desc_data,
    input  logic                          i_desc_rd,
    input  logic                          i_resp_wr,
    input  logic [7:0]                    i_resp_desc_id,
    input  logic [1:0]                    i_resp_ch_sel,
    output logic                          o_resp_wready,
    input  logic                          i_host_resp_rd,
    output logic                          o_host_resp_rready,
    output logic [7:0]                    o_host_resp_desc_id,
    output logic [1:0]                    o_host_resp_ch_sel,
    output logic [$clog2(DESC_DEPTH):0]   o_desc_count,
    output logic [$clog2(RESP_DEPTH):0]   o_resp_count,
    output logic                          o_irq,
    output logic                          o_overflow,
    input  logic                          i_err_clr
);
    localparam int DCW = $clog2(DESC_DEPTH) + 1;
    localparam int RCW = $clog2(RESP_DEPTH) + 1;
    localparam int DFW = 8 + 2 + DESC_DATA_W;
    localparam logic [DCW-1:0] DESC_FULL = DCW'(DESC_DEPTH);
    localparam logic [RCW-1:0] RESP_FULL = RCW'(RESP_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic           clr;
    logic           desc_push;
    logic           desc_pop;
    logic           resp_push;
    logic           resp_pop;
    logic           desc_empty;
    logic           resp_empty;
    logic [DFW-1:0] desc_head;
    logic [9:0]     resp_head;
    logic [DCW-1:0] desc_count_next;
    logic           host_desc_wready_q;
    logic           overflow_q;

    // A flush request discards anything pushed in the same cycle.
    assign clr = i_flush || (state == FLUSH);

    assign o_desc_rready      = (state == RUN) && !desc_empty;
    assign o_resp_wready      = (state == RUN) && (o_resp_count != RESP_FULL);
    assign o_host_resp_rready = (state != FLUSH) && !resp_empty;
    assign o_host_desc_wready = host_desc_wready_q;
    assign o_overflow         = overflow_q;
    assign o_irq              = (state == RUN) && !resp_empty;

    assign desc_push = i_host_desc_wr && o_host_desc_wready;
    assign desc_pop  = i_desc_rd && o_desc_rready;
    assign resp_push = i_resp_wr && o_resp_wready;
    assign resp_pop  = i_host_resp_rd && o_host_resp_rready;

    // Head fields read as zero whenever no valid entry is presented.
    assign o_desc_data         = o_desc_rready ? desc_head[DESC_DATA_W-1:0] : '0;
    assign o_desc_id           = o_desc_rready ? desc_head[DESC_DATA_W +: 8] : '0;
    assign o_desc_ch_sel       = o_desc_rready ? desc_head[DESC_DATA_W+8 +: 2] : '0;
    assign o_host_resp_desc_id = o_host_resp_rready ? resp_head[7:0] : '0;
    assign o_host_resp_ch_sel  = o_host_resp_rready ? resp_head[9:8] : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_flush) state_next = FLUSH;
                     else if (aenable) state_next = RUN;
            RUN:     if (i_flush) state_next = FLUSH;
                     else if (!aenable) state_next = IDLE;
            FLUSH:   if (!i_flush) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        desc_count_next = o_desc_count;
        if (clr)
            desc_count_next = '0;
        else if (desc_push && !desc_pop)
            desc_count_next = o_desc_count + 1'b1;
        else if (!desc_push && desc_pop)
            desc_count_next = o_desc_count - 1'b1;
    end

    // Host push readiness is registered from next-cycle state and occupancy.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state              <= IDLE;
            host_desc_wready_q <= 1'b0;
            overflow_q         <= 1'b0;
        end else begin
            state              <= state_next;
            host_desc_wready_q <= (state_next != FLUSH) && (desc_count_next != DESC_FULL);
            if (i_host_desc_wr && !o_host_desc_wready && (state != FLUSH))
                overflow_q <= 1'b1;
            else if (i_err_clr)
                overflow_q <= 1'b0;
        end
    end

    dma_queue_fifo #(
        .DEPTH (DESC_DEPTH),
        .W     (DFW)
    ) u_desc_fifo (
        .clk   (aclk),
        .rst   (areset),
        .clr   (clr),
        .push  (desc_push),
        .pop   (desc_pop),
        .wdata ({i_host_desc_ch, i_host_desc_id, i_host_desc_data}),
        .rdata (desc_head),
        .count (o_desc_count),
        .empty (desc_empty)
    );

    dma_queue_fifo #(
        .DEPTH (RESP_DEPTH),
        .W     (10)
    ) u_resp_fifo (
        .clk   (aclk),
        .rst   (areset),
        .clr   (clr),
        .push  (resp_push),
        .pop   (resp_pop),
        .wdata ({i_resp_ch_sel, i_resp_desc_id}),
        .rdata (resp_head),
        .count (o_resp_count),
        .empty (resp_empty)
    );
endmodule

// File: tb/tb_dma_desc_queue.sv
// tb/tb_dma_desc_queue.sv - directed scoreboard bench for dma_desc_queue

module tb_dma_desc_queue;
    localparam int DD = 8;
    localparam int RD = 8;
    localparam int DW = 64;

    logic          aclk = 1'b0;
    logic          areset;
    logic          aenable;
    logic          i_flush;
    logic          i_host_desc_wr;
    logic [7:0]    i_host_desc_id;
    logic [1:0]    i_host_desc_ch;
    logic [DW-1:0] i_host_desc_data;
    logic          o_host_desc_wready;
    logic          o_desc_rready;
    logic [1:0]    o_desc_ch_sel;
    logic [7:0]    o_desc_id;
    logic [DW-1:0] o_desc_data;
    logic          i_desc_rd;
    logic          i_resp_wr;
    logic [7:0]    i_resp_desc_id;
    logic [1:0]    i_resp_ch_sel;
    logic          o_resp_wready;
    logic          i_host_resp_rd;
    logic          o_host_resp_rready;
    logic [7:0]    o_host_resp_desc_id;
    logic [1:0]    o_host_resp_ch_sel;
    logic [3:0]    o_desc_count;
    logic [3:0]    o_resp_count;
    logic          o_irq;
    logic          o_overflow;
    logic          i_err_clr;

    always #5 aclk = ~aclk;

    dma_desc_queue #(
        .DESC_DEPTH  (DD),
        .RESP_DEPTH  (RD),
        .DESC_DATA_W (DW)
    ) dut (
        .aclk                (aclk),
        .areset              (areset),
        .aenable             (aenable),
        .i_flush             (i_flush),
        .i_host_desc_wr      (i_host_desc_wr),
        .i_host_desc_id      (i_host_desc_id),
        .i_host_desc_ch      (i_host_desc_ch),
        .i_host_desc_data    (i_host_desc_data),
        .o_host_desc_wready  (o_host_desc_wready),
        .o_desc_rready       (o_desc_rready),
        .o_desc_ch_sel       (o_desc_ch_sel),
        .o_desc_id           (o_desc_id),
        .o_desc_data         (o_desc_data),
        .i_desc_rd           (i_desc_rd),
        .i_resp_wr           (i_resp_wr),
        .i_resp_desc_id      (i_resp_desc_id),
        .i_resp_ch_sel       (i_resp_ch_sel),
        .o_resp_wready       (o_resp_wready),
        .i_host_resp_rd      (i_host_resp_rd),
        .o_host_resp_rready  (o_host_resp_rready),
        .o_host_resp_desc_id (o_host_resp_desc_id),
        .o_host_resp_ch_sel  (o_host_resp_ch_sel),
        .o_desc_count        (o_desc_count),
        .o_resp_count        (o_resp_count),
        .o_irq               (o_irq),
        .o_overflow          (o_overflow),
        .i_err_clr           (i_err_clr)
    );

    typedef struct packed {
        logic [7:0]    id;
        logic [1:0]    ch;
        logic [DW-1:0] data;
    } desc_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] ch;
    } resp_t;

    desc_t dsb[$];
    resp_t rsb[$];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_desc(input logic [7:0] id, input logic [1:0] ch, input bit accept);
        desc_t d;
        d.id   = id;
        d.ch   = ch;
        d.data = {$urandom(), $urandom()};
        i_host_desc_wr   = 1'b1;
        i_host_desc_id   = d.id;
        i_host_desc_ch   = d.ch;
        i_host_desc_data = d.data;
        if (accept) dsb.push_back(d);
        tick();
        i_host_desc_wr = 1'b0;
    endtask

    task automatic pop_desc(input string tag);
        desc_t e;
        if (dsb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(dsb.size()), 64'd1);
        end else begin
            e = dsb.pop_front();
            chk({tag, "_rready"}, 64'(o_desc_rready), 64'd1);
            chk({tag, "_id"}, 64'(o_desc_id), 64'(e.id));
            chk({tag, "_ch"}, 64'(o_desc_ch_sel), 64'(e.ch));
            chk({tag, "_data"}, o_desc_data, e.data);
            i_desc_rd = 1'b1;
            tick();
            i_desc_rd = 1'b0;
        end
    endtask

    task automatic write_resp(input logic [7:0] id, input logic [1:0] ch);
        resp_t r;
        r.id = id;
        r.ch = ch;
        chk("resp_wready", 64'(o_resp_wready), 64'd1);
        i_resp_wr      = 1'b1;
        i_resp_desc_id = id;
        i_resp_ch_sel  = ch;
        rsb.push_back(r);
        tick();
        i_resp_wr = 1'b0;
    endtask

    task automatic pop_resp(input string tag);
        resp_t e;
        if (rsb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(rsb.size()), 64'd1);
        end else begin
            e = rsb.pop_front();
            chk({tag, "_rready"}, 64'(o_host_resp_rready), 64'd1);
            chk({tag, "_id"}, 64'(o_host_resp_desc_id), 64'(e.id));
            chk({tag, "_ch"}, 64'(o_host_resp_ch_sel), 64'(e.ch));
            i_host_resp_rd = 1'b1;
            tick();
            i_host_resp_rd = 1'b0;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_hdw"}, 64'(o_host_desc_wready), 64'd0);
        chk({tag, "_drr"}, 64'(o_desc_rready), 64'd0);
        chk({tag, "_did"}, 64'(o_desc_id), 64'd0);
        chk({tag, "_dch"}, 64'(o_desc_ch_sel), 64'd0);
        chk({tag, "_ddat"}, o_desc_data, 64'd0);
        chk({tag, "_rwr"}, 64'(o_resp_wready), 64'd0);
        chk({tag, "_hrr"}, 64'(o_host_resp_rready), 64'd0);
        chk({tag, "_rid"}, 64'(o_host_resp_desc_id), 64'd0);
        chk({tag, "_rch"}, 64'(o_host_resp_ch_sel), 64'd0);
        chk({tag, "_dcnt"}, 64'(o_desc_count), 64'd0);
        chk({tag, "_rcnt"}, 64'(o_resp_count), 64'd0);
        chk({tag, "_irq"}, 64'(o_irq), 64'd0);
        chk({tag, "_ovf"}, 64'(o_overflow), 64'd0);
    endtask

    initial begin
        desc_t d;
        desc_t e;

        areset = 1'b1; aenable = 1'b0; i_flush = 1'b0; i_err_clr = 1'b0;
        i_host_desc_wr = 1'b0; i_host_desc_id = '0; i_host_desc_ch = '0; i_host_desc_data = '0;
        i_desc_rd = 1'b0; i_resp_wr = 1'b0; i_resp_desc_id = '0; i_resp_ch_sel = '0;
        i_host_resp_rd = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");

        // Basic descriptor flow
        areset = 1'b0; aenable = 1'b1;
        tick();
        push_desc(8'h11, 2'd0, 1'b1);
        chk("first_rready", 64'(o_desc_rready), 64'd1);
        push_desc(8'h22, 2'd1, 1'b1);
        chk("two_count", 64'(o_desc_count), 64'd2);
        pop_desc("pop11");
        pop_desc("pop22");
        chk("drained_rready", 64'(o_desc_rready), 64'd0);
        chk("drained_count", 64'(o_desc_count), 64'd0);

        // Fill, rejected push with simultaneous pop, overflow set/clear
        for (int i = 0; i < DD; i++) push_desc(8'h30 + 8'(i), 2'(i), 1'b1);
        chk("full_wready", 64'(o_host_desc_wready), 64'd0);
        chk("full_count", 64'(o_desc_count), 64'd8);
        e = dsb.pop_front();
        chk("full_head_id", 64'(o_desc_id), 64'(e.id));
        i_host_desc_wr = 1'b1; i_host_desc_id = 8'h99; i_desc_rd = 1'b1;
        tick();
        i_host_desc_wr = 1'b0; i_desc_rd = 1'b0;
        chk("ovf_set", 64'(o_overflow), 64'd1);
        chk("ovf_count", 64'(o_desc_count), 64'd7);
        chk("ovf_wready", 64'(o_host_desc_wready), 64'd1);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("ovf_clr", 64'(o_overflow), 64'd0);
        while (dsb.size() > 0) pop_desc("drain_full");
        chk("drain_full_count", 64'(o_desc_count), 64'd0);

        // Wrap-around at steady occupancy 3
        for (int i = 0; i < 3; i++) push_desc(8'h40 + 8'(i), 2'(i), 1'b1);
        for (int i = 0; i < 20; i++) begin
            e = dsb.pop_front();
            chk("wrap_id", 64'(o_desc_id), 64'(e.id));
            chk("wrap_data", o_desc_data, e.data);
            d.id = 8'h50 + 8'(i);
            d.ch = 2'(i);
            d.data = {$urandom(), $urandom()};
            i_host_desc_wr = 1'b1; i_host_desc_id = d.id; i_host_desc_ch = d.ch;
            i_host_desc_data = d.data; i_desc_rd = 1'b1;
            dsb.push_back(d);
            tick();
            i_host_desc_wr = 1'b0; i_desc_rd = 1'b0;
            chk("wrap_count", 64'(o_desc_count), 64'd3);
        end
        while (dsb.size() > 0) pop_desc("drain_wrap");

        // Response path and interrupt
        write_resp(8'h5A, 2'd1);
        chk("irq_on", 64'(o_irq), 64'd1);
        chk("resp_count1", 64'(o_resp_count), 64'd1);
        pop_resp("resp5a");
        chk("irq_off", 64'(o_irq), 64'd0);
        for (int i = 0; i < RD; i++) write_resp(8'h60 + 8'(i), 2'(i));
        chk("resp_full_wready", 64'(o_resp_wready), 64'd0);
        chk("resp_full_count", 64'(o_resp_count), 64'd8);
        i_resp_wr = 1'b1; i_resp_desc_id = 8'h77; i_resp_ch_sel = 2'd2;
        tick();
        tick();
        chk("resp_held_count", 64'(o_resp_count), 64'd8);
        pop_resp("resp_hold_pop");
        chk("resp_after_pop_count", 64'(o_resp_count), 64'd7);
        chk("resp_after_pop_wready", 64'(o_resp_wready), 64'd1);
        rsb.push_back('{id: 8'h77, ch: 2'd2});
        tick();
        i_resp_wr = 1'b0;
        chk("resp_retry_count", 64'(o_resp_count), 64'd8);
        while (rsb.size() > 0) pop_resp("drain_resp");

        // Flush mid-operation
        for (int i = 0; i < 4; i++) push_desc(8'h80 + 8'(i), 2'(i), 1'b1);
        write_resp(8'h90, 2'd0);
        write_resp(8'h91, 2'd3);
        i_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_hdw", 64'(o_host_desc_wready), 64'd0);
            chk("flush_drr", 64'(o_desc_rready), 64'd0);
            chk("flush_rwr", 64'(o_resp_wready), 64'd0);
            chk("flush_hrr", 64'(o_host_resp_rready), 64'd0);
            chk("flush_dcnt", 64'(o_desc_count), 64'd0);
            chk("flush_rcnt", 64'(o_resp_count), 64'd0);
            chk("flush_irq", 64'(o_irq), 64'd0);
        end
        dsb.delete();
        rsb.delete();
        i_flush = 1'b0;
        tick();
        chk("post_flush_idle_hdw", 64'(o_host_desc_wready), 64'd1);
        chk("post_flush_idle_rwr", 64'(o_resp_wready), 64'd0);
        tick();
        chk("post_flush_run_rwr", 64'(o_resp_wready), 64'd1);
        push_desc(8'hA5, 2'd2, 1'b1);
        pop_desc("post_flush");

        // Disabled queue: arbiter side frozen, host side live
        push_desc(8'hB1, 2'd1, 1'b1);
        push_desc(8'hB2, 2'd0, 1'b1);
        aenable = 1'b0;
        tick();
        chk("dis_rready", 64'(o_desc_rready), 64'd0);
        i_desc_rd = 1'b1;
        tick();
        i_desc_rd = 1'b0;
        chk("dis_rd_ignored", 64'(o_desc_count), 64'd2);
        push_desc(8'hB3, 2'd3, 1'b1);
        chk("dis_host_push", 64'(o_desc_count), 64'd3);
        aenable = 1'b1;
        tick();
        while (dsb.size() > 0) pop_desc("reenable");

        // Synchronous reset mid-traffic
        push_desc(8'hC1, 2'd1, 1'b1);
        write_resp(8'hC2, 2'd1);
        i_host_desc_wr = 1'b1; i_host_desc_id = 8'hC3;
        i_resp_wr = 1'b1; i_resp_desc_id = 8'hC4;
        areset = 1'b1;
        tick();
        i_host_desc_wr = 1'b0; i_resp_wr = 1'b0;
        check_idle_zero("midreset");
        areset = 1'b0;
        dsb.delete();
        rsb.delete();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dma_desc_queue.md
Name: dma_desc_queue

Overview:
Descriptor/response queue at the far end of the DMA descriptor arbiter. The host side pushes descriptors, each tagged with an id and a target channel. The head descriptor is presented to the arbiter, which pops it when the selected channel consumes it. In the other direction, the block accepts completion responses (desc id + channel) from the arbiter into a response FIFO that the host drains, and raises an interrupt level while responses are pending.

Parameters:
DESC_DEPTH, 8, descriptor FIFO entries; power of 2, >= 2.
RESP_DEPTH, 8, response FIFO entries; power of 2, >= 2.
DESC_DATA_W, 64, descriptor payload width (src/dst/len packed by host).

Ports:
aclk  in  1  clock, all logic rising-edge.
areset  in  1  synchronous, active-high reset.
aenable  in  1  queue enable; low holds both arbiter-side handshakes inactive.
i_flush  in  1  level; discards both FIFOs' contents.
i_host_desc_wr  in  1  host descriptor push strobe.
i_host_desc_id  in  8  descriptor id.
i_host_desc_ch  in  2  target channel; bit0 selects channel, bit1 reserved (stored, passed through).
i_host_desc_data  in  DESC_DATA_W  descriptor payload.
o_host_desc_wready  out  1  descriptor FIFO can accept a push.
o_desc_rready  out  1  head descriptor valid toward arbiter.
o_desc_ch_sel  out  2  head descriptor channel.
o_desc_id  out  8  head descriptor id.
o_desc_data  out  DESC_DATA_W  head descriptor payload.
i_desc_rd  in  1  arbiter pop strobe.
i_resp_wr  in  1  arbiter response write request.
i_resp_desc_id  in  8  completed descriptor id.
i_resp_ch_sel  in  2  channel that completed it.
o_resp_wready  out  1  response FIFO accepts a write.
i_host_resp_rd  in  1  host response pop strobe.
o_host_resp_rready  out  1  response head valid.
o_host_resp_desc_id  out  8  response head id.
o_host_resp_ch_sel  out  2  response head channel.
o_desc_count  out  $clog2(DESC_DEPTH)+1  descriptor occupancy.
o_resp_count  out  $clog2(RESP_DEPTH)+1  response occupancy.
o_irq  out  1  level, high while response FIFO is non-empty and state is RUN.
o_overflow  out  1  sticky error flag.
i_err_clr  in  1  clears o_overflow.

Behaviour:
- Reset (areset=1 at a clock edge): pointers = 0, counts = 0, state = IDLE. All outputs are 0; data outputs are 0.
- FIFOs: first-word-fall-through. Read/write pointers are $clog2(DEPTH)+1 bits wide; the MSB differs on full. Pointer wrap is natural modulo 2*DEPTH.
- Control FSM:
  - IDLE -> RUN when aenable=1 and i_flush=0.
  - IDLE -> FLUSH when i_flush=1 (flush has priority).
  - RUN -> FLUSH when i_flush=1.
  - RUN -> IDLE when aenable=0.
  - FLUSH: on every cycle in this state, both FIFOs' pointers are zeroed. Exit to IDLE when i_flush=0; IDLE re-enters RUN the following cycle if aenable=1.
- Handshake gating:
  - o_desc_rready = RUN and desc non-empty.
  - o_resp_wready = RUN and resp not full.
  - o_host_desc_wready = not FLUSH and desc not full.
  - o_host_resp_rready = not FLUSH and resp non-empty.
  - Host-side traffic continues in IDLE.
- Push/pop rules:
  - Desc push occurs on i_host_desc_wr && o_host_desc_wready.
  - Desc pop occurs on i_desc_rd && o_desc_rready; i_desc_rd while rready=0 is ignored.
  - Resp write occurs on i_resp_wr && o_resp_wready; the arbiter holds i_resp_wr and id/ch stable until accepted.
  - Resp pop occurs on i_host_resp_rd && o_host_resp_rready.
- Latency: a push into an empty FIFO produces a valid head on the next cycle; there is no same-cycle bypass. A pop advances the head on the next cycle.
- Full boundary: wready is derived from registered occupancy. A push while full is rejected even if a pop happens in the same cycle.
- Simultaneous push+pop with non-empty, non-full occupancy: count unchanged, both succeed.
- Overflow: i_host_desc_wr while o_host_desc_wready=0 and state != FLUSH sets o_overflow the next cycle. i_err_clr clears it; if set and clear coincide, set wins.
- Counts: o_desc_count and o_resp_count are registered and range 0..DEPTH.
- Flush mid-operation: any pending i_resp_wr is not accepted (wready=0) and must be retried after RUN resumes. A flush asserted in the same cycle as a push discards that push.
- o_desc_ch_sel[1] is stored and presented unmodified.

Test Plan:
- Reset, then aenable=1; push id 0x11 ch 0, 0x22 ch 1 -> o_desc_rready=1 one cycle after the first push; head id 0x11/ch 0; pop -> head 0x22/ch 1; second pop -> rready=0, o_desc_count=0.
- Push 8 descriptors (DESC_DEPTH=8) -> o_host_desc_wready=0, count=8. Ninth push with simultaneous pop -> push rejected, o_overflow=1, count=7. i_err_clr -> o_overflow=0.
- Wrap-around: 20 push/pop pairs with occupancy held at 3 -> ids emerge in order with no loss; count stays 3.
- Response path: i_resp_wr with id 0x5A ch 1 -> accepted; o_irq=1 next cycle; host pop returns 0x5A/1; o_irq=0. Fill 8 responses -> o_resp_wready=0, and an arbiter write held high is accepted only after one host pop.
- Flush: 4 descriptors and 2 responses queued, i_flush=1 for 3 cycles -> all ready/valid outputs 0, counts 0. Release flush -> IDLE then RUN; a new push appears at the head.
- aenable=0 with 2 queued descriptors -> o_desc_rready=0 and i_desc_rd ignored, but host push still accepted. Synchronous reset mid-traffic -> all outputs 0 at the next edge.
